// File: rtl/savomax_sync_gen.sv
// savomax_sync_gen: progressive PAL/NTSC HSYNC/VSYNC/CSYNC generator; format and enable
// changes take effect only at field boundaries, so no partial or short fields are produced.
module savomax_sync_gen #(
   parameter int CLK_FREQ    = 1_000_000,
   parameter int LINE_CLKS   = 64,
   parameter int HSYNC_CLKS  = 5,
   parameter int PAL_LINES   = 312,
   parameter int NTSC_LINES  = 262,
   parameter int VSYNC_LINES = 3
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       enable_in,
   input  logic       format_sel_in,
   output logic       hsync_out,
   output logic       vsync_out,
   output logic       csync_out,
   output logic       field_start_out,
   output logic [2:0] format_out,
   output logic [9:0] line_out
);
   if (CLK_FREQ < 1 || LINE_CLKS < 8 || LINE_CLKS > 65535 || HSYNC_CLKS < 1 || HSYNC_CLKS >= LINE_CLKS ||
       VSYNC_LINES < 1 || VSYNC_LINES >= NTSC_LINES || PAL_LINES > 1023 || NTSC_LINES > 1023) begin : g_bad_params
      $error("savomax_sync_gen: illegal parameter set");
   end
   typedef enum logic {IDLE, ACTIVE} state_t;
   state_t      state;
   logic [15:0] h_cnt, h_nxt;
   logic [9:0]  v_cnt, v_nxt, field_lines;
   logic        h_last, boundary, start, run_nxt, hs_n, vs_n;
   always_comb begin
      h_last   = h_cnt == 16'(LINE_CLKS - 1);
      boundary = state == ACTIVE && h_last && v_cnt == field_lines - 10'd1;
      start    = state == IDLE ? enable_in : boundary && enable_in;
      run_nxt  = state == IDLE ? enable_in : !(boundary && !enable_in);
      h_nxt    = (state == IDLE || h_last) ? 16'd0 : h_cnt + 16'd1;
      v_nxt    = (state == IDLE || boundary) ? 10'd0 : h_last ? v_cnt + 10'd1 : v_cnt;
      hs_n     = !(run_nxt && h_nxt < 16'(HSYNC_CLKS));
      vs_n     = !(run_nxt && v_nxt < 10'(VSYNC_LINES));
   end
   // Outputs are computed from the next counter values so they align with the counters.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state           <= IDLE;
         h_cnt           <= '0;
         v_cnt           <= '0;
         field_lines     <= 10'(NTSC_LINES);
         hsync_out       <= 1'b1;
         vsync_out       <= 1'b1;
         csync_out       <= 1'b1;
         field_start_out <= 1'b0;
         format_out      <= 3'b000;
         line_out        <= '0;
      end else begin
         state           <= run_nxt ? ACTIVE : IDLE;
         h_cnt           <= h_nxt;
         v_cnt           <= v_nxt;
         if (start) field_lines <= format_sel_in ? 10'(PAL_LINES) : 10'(NTSC_LINES);
         hsync_out       <= hs_n;
         vsync_out       <= vs_n;
         csync_out       <= hs_n ~^ vs_n;
         field_start_out <= start;
         format_out      <= !run_nxt ? 3'b000 : start ? (format_sel_in ? 3'b100 : 3'b010) : format_out;
         line_out        <= v_nxt;
      end
   end
endmodule

// File: tb/tb_savomax_sync_gen.sv
// tb_savomax_sync_gen: randomized bench comparing the generator against a field-position model,
// plus directed field-period, format-switch, enable-drop and reset checks.
module tb_savomax_sync_gen;
   localparam int LC = 16, HS = 3, PL = 12, NL = 9, VS = 2;
   logic clk = 0, rst = 1, en = 0, sel = 0;
   logic hs, vs, cs, fs;
   logic [2:0] fmt;
   logic [9:0] line;
   int total = 0, bad = 0, cyc = 0, fs_count = 0;
   bit chk_en = 0, prev_vs = 1;
   int falls[$];
   bit m_act = 0;
   int m_pos = 0, m_fl = NL, m_fmt = 0;

   savomax_sync_gen #(.CLK_FREQ(1_000_000), .LINE_CLKS(LC), .HSYNC_CLKS(HS), .PAL_LINES(PL),
                      .NTSC_LINES(NL), .VSYNC_LINES(VS)) dut (
      .clk_in(clk), .rst_in(rst), .enable_in(en), .format_sel_in(sel),
      .hsync_out(hs), .vsync_out(vs), .csync_out(cs), .field_start_out(fs),
      .format_out(fmt), .line_out(line));

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Model: one position counter per field; line/column follow by division.
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_act = 0; m_pos = 0; m_fmt = 0;
      end else if (!m_act) begin
         if (en) begin m_act = 1; m_pos = 0; m_fl = sel ? PL : NL; m_fmt = sel ? 4 : 2; end
      end else begin
         m_pos++;
         if (m_pos == LC * m_fl) begin
            m_pos = 0;
            if (en) begin m_fl = sel ? PL : NL; m_fmt = sel ? 4 : 2; end
            else begin m_act = 0; m_fmt = 0; end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         automatic int h = m_pos % LC, v = m_pos / LC;
         automatic bit e_hs = !(m_act && h < HS), e_vs = !(m_act && v < VS);
         automatic bit e_cs = e_vs ? e_hs : !e_hs;
         automatic bit e_fs = m_act && m_pos == 0;
         automatic int e_line = m_act ? v : 0;
         check("model", int'({hs, vs, cs, fs, fmt, line}), int'({e_hs, e_vs, e_cs, e_fs, 3'(m_fmt), 10'(e_line)}));
         if (fs) fs_count++;
         if (prev_vs && !vs) falls.push_back(cyc);
         prev_vs = vs;
      end
   end

   task automatic wait_line(input int l, input int budget);
      int n = 0;
      do begin @(negedge clk); n++; end while (line != 10'(l) && n < budget);
      if (line != 10'(l)) check("wait_line_timeout", int'(line), l);
   endtask

   task automatic wait_falls(input int n, input int budget);
      int k = 0;
      while (falls.size() < n && k < budget) begin @(negedge clk); k++; end
      if (falls.size() < n) check("wait_falls_timeout", falls.size(), n);
   endtask

   initial begin
      int n, k;
      repeat (3) @(negedge clk);
      chk_en = 1;
      rst = 0;
      repeat (100) @(negedge clk);
      check("idle_syncs", int'({hs, vs, cs}), 7);
      check("idle_fmt", int'(fmt), 0);
      check("idle_no_fs", fs_count, 0);
      sel = 1; en = 1;
      @(negedge clk);
      check("first_edge", int'({hs, vs, cs, fs, fmt}), int'({4'b0011, 3'b100}));
      wait_falls(3, 1000);
      if (falls.size() >= 3) begin
         check("pal_period0", falls[1] - falls[0], 192);
         check("pal_period1", falls[2] - falls[1], 192);
      end
      check("pal_fmt", int'(fmt), 4);
      wait_line(5, 400);
      sel = 0;
      @(negedge clk);
      check("fmt_mid_field", int'(fmt), 4);
      n = falls.size();
      wait_falls(n + 2, 1000);
      if (falls.size() >= n + 2 && n >= 1) begin
         check("toggle_field_len", falls[n] - falls[n - 1], 192);
         check("ntsc_field_len", falls[n + 1] - falls[n], 144);
      end
      check("ntsc_fmt", int'(fmt), 2);
      wait_line(4, 400);
      en = 0;
      n = falls.size();
      k = 0;
      while (fmt != 3'b000 && k < 400) begin @(negedge clk); k++; end
      check("drop_to_idle", int'(fmt), 0);
      if (falls.size() > 0) check("drop_completes_field", cyc - falls[falls.size() - 1], 144);
      check("drop_no_new_fall", falls.size(), n);
      k = fs_count;
      repeat (50) @(negedge clk);
      check("drop_no_pulse", fs_count, k);
      check("drop_syncs", int'({hs, vs, cs, line}), int'({3'b111, 10'd0}));
      sel = 1; en = 1;
      wait_line(8, 400);
      repeat (10) @(negedge clk);
      rst = 1;
      @(negedge clk);
      check("rst_mid_field", int'({hs, vs, cs, fs, fmt, line}), int'({4'b1110, 3'b000, 10'd0}));
      rst = 0;
      @(negedge clk);
      check("restart", int'({hs, vs, cs, fs, fmt, line}), int'({4'b0011, 3'b100, 10'd0}));
      repeat (2) @(negedge clk);
      check("restart_serration", int'({hs, vs, cs}), 3'b001);
      repeat (3000) begin
         @(negedge clk);
         rst = ($urandom % 300) == 0;
         en  = ($urandom % 20) != 0;
         if (($urandom % 50) == 0) sel = ~sel;
      end
      rst = 0;
      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
